frame_sequencer: RTL and testbench

Per-frame controller for the fighting-game logic. Once per video frame it snapshots both players' controller inputs and then runs the game-logic update as three ordered phases: movement, collision and animation/sprite. Each phase uses a start/done handshake. After the last phase it issues a commit pulse so that player state, position and sprite outputs change only between frames. It sits between the frame-tick source (vblank, already synchronised into `sys_clk`) and the `game_logic` datapath. It also counts frames and flags overruns and stuck phases.

---
 rtl/frame_sequencer.sv | 149 ++++++++++++++
 tb/tb_frame_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: once-per-frame controller that snapshots both players'
// inputs and walks the game logic through its move/collide/animate phases.
//
// Ports:
//   sys_clk, rst                       clock, async active-low reset
//   frame_tick                         one-cycle vblank pulse
//   p1_inputs_raw, p2_inputs_raw       live controller buttons
//   p1_inputs_latched, p2_inputs_latched  per-frame input snapshot
//   step_start, step_sel, step_done    phase start/done handshake
//   commit                             publish new game state
//   frame_busy                         high from LATCH through COMMIT
//   frame_count                        committed frames (wraps)
//   overrun, timeout                   sticky error flags
module frame_sequencer #(
    parameter int INPUT_DEPTH       = 5,
    parameter int TIMEOUT_CYCLES    = 1023,
    parameter int FRAME_COUNT_DEPTH = 16
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic                         frame_tick,
    input  logic [INPUT_DEPTH-1:0]       p1_inputs_raw,
    input  logic [INPUT_DEPTH-1:0]       p2_inputs_raw,
    output logic [INPUT_DEPTH-1:0]       p1_inputs_latched,
    output logic [INPUT_DEPTH-1:0]       p2_inputs_latched,
    output logic                         step_start,
    output logic [1:0]                   step_sel,
    input  logic                         step_done,
    output logic                         commit,
    output logic                         frame_busy,
    output logic [FRAME_COUNT_DEPTH-1:0] frame_count,
    output logic                         overrun,
    output logic                         timeout
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ISSUE,
        WAIT,
        COMMIT
    } state_t;

    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [FRAME_COUNT_DEPTH-1:0] COUNT_ONE = 1;
    localparam logic [1:0] LAST_PHASE = 2'd2;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_nxt;
    logic [1:0]  sel_nxt;
    logic        latch_en;
    logic        count_inc;
    logic        timeout_set;
    logic        overrun_set;

    // Handshake strobes are pure decodes of the state register.
    assign step_start = (state == ISSUE);
    assign commit     = (state == COMMIT);
    assign frame_busy = (state != IDLE);

    // A tick that lands while a frame is in flight is dropped, not queued.
    assign overrun_set = frame_tick && (state != IDLE);

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sel_nxt      = step_sel;
        wait_cnt_nxt = wait_cnt;
        latch_en     = 1'b0;
        count_inc    = 1'b0;
        timeout_set  = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_tick) begin
                    state_nxt = LATCH;
                end
            end
            LATCH: begin
                latch_en  = 1'b1;
                sel_nxt   = 2'd0;
                state_nxt = ISSUE;
            end
            ISSUE: begin
                wait_cnt_nxt = 16'd0;
                state_nxt    = WAIT;
            end
            WAIT: begin
                // Done has priority: hitting the limit in the same
                // cycle as done is a normal completion.
                if (step_done || (wait_cnt == WAIT_LIMIT)) begin
                    timeout_set = !step_done;
                    if (step_sel == LAST_PHASE) begin
                        state_nxt = COMMIT;
                    end else begin
                        sel_nxt   = step_sel + 2'd1;
                        state_nxt = ISSUE;
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            COMMIT: begin
                count_inc = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            wait_cnt          <= '0;
            step_sel          <= '0;
            p1_inputs_latched <= '0;
            p2_inputs_latched <= '0;
            frame_count       <= '0;
            overrun           <= 1'b0;
            timeout           <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            step_sel <= sel_nxt;
            if (latch_en) begin
                p1_inputs_latched <= p1_inputs_raw;
                p2_inputs_latched <= p2_inputs_raw;
            end
            if (count_inc) begin
                frame_count <= frame_count + COUNT_ONE;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end
            if (timeout_set) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed and randomized frames checked against a
// timeline model of the frame sequencer.
module tb_frame_sequencer;

    localparam int ID  = 5;
    localparam int TO  = 8;
    localparam int FCD = 4;

    logic           sys_clk;
    logic           rst;
    logic           frame_tick;
    logic [ID-1:0]  p1_raw;
    logic [ID-1:0]  p2_raw;
    logic [ID-1:0]  p1_lat;
    logic [ID-1:0]  p2_lat;
    logic           step_start;
    logic [1:0]     step_sel;
    logic           step_done;
    logic           commit;
    logic           frame_busy;
    logic [FCD-1:0] frame_count;
    logic           overrun;
    logic           timeout;

    int n_chk  = 0;
    int n_fail = 0;

    int m_count = 0;
    bit m_ov    = 0;
    bit m_to    = 0;
    int m_sel   = 0;

    frame_sequencer #(
        .INPUT_DEPTH      (ID),
        .TIMEOUT_CYCLES   (TO),
        .FRAME_COUNT_DEPTH(FCD)
    ) dut (
        .sys_clk          (sys_clk),
        .rst              (rst),
        .frame_tick       (frame_tick),
        .p1_inputs_raw    (p1_raw),
        .p2_inputs_raw    (p2_raw),
        .p1_inputs_latched(p1_lat),
        .p2_inputs_latched(p2_lat),
        .step_start       (step_start),
        .step_sel         (step_sel),
        .step_done        (step_done),
        .commit           (commit),
        .frame_busy       (frame_busy),
        .frame_count      (frame_count),
        .overrun          (overrun),
        .timeout          (timeout)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_state();
        chk("idle_busy", frame_busy, 0);
        chk("idle_start", step_start, 0);
        chk("idle_commit", commit, 0);
        chk("idle_sel", step_sel, m_sel);
        chk("frame_count", frame_count, m_count);
        chk("overrun", overrun, m_ov);
        chk("timeout", timeout, m_to);
    endtask

    // d0..d2: WAIT cycle of each phase in which done is raised
    // (beyond TO means never). ov_a/ov_b: cycles with an extra tick.
    task automatic run_frame(input logic [ID-1:0] p1,
                             input logic [ID-1:0] p2,
                             input int d0, input int d1, input int d2,
                             input int ov_a, input int ov_b);
        int d[3];
        int w[3];
        int issue_c[3];
        int done_c[3];
        int pos;
        int len;
        int ph;
        bit is_issue;
        bit is_done;
        d[0] = d0;
        d[1] = d1;
        d[2] = d2;
        pos = 1;
        for (int i = 0; i < 3; i++) begin
            w[i]       = (d[i] <= TO) ? d[i] : TO;
            issue_c[i] = pos + 1;
            done_c[i]  = (d[i] <= TO) ? issue_c[i] + d[i] : -1;
            pos        = issue_c[i] + w[i];
        end
        len = pos + 1;

        @(posedge sys_clk);
        #1;
        frame_tick = 1'b1;
        step_done  = 1'b0;
        p1_raw     = p1;
        p2_raw     = p2;
        @(negedge sys_clk);
        chk_idle_state();

        for (int c = 1; c <= len; c++) begin
            @(posedge sys_clk);
            #1;
            is_issue = 0;
            is_done  = 0;
            ph       = 0;
            for (int i = 0; i < 3; i++) begin
                if (c == issue_c[i]) is_issue = 1;
                if (c == done_c[i]) is_done = 1;
                if (c >= issue_c[i]) ph = i;
            end
            frame_tick = (c == ov_a) || (c == ov_b);
            step_done  = is_done ||
                ((is_issue || c == 1 || c == len) &&
                 ($urandom_range(0, 3) == 0));
            if (c >= 2) begin
                p1_raw = ID'($urandom);
                p2_raw = ID'($urandom);
            end
            @(negedge sys_clk);
            chk("busy", frame_busy, 1);
            chk("step_start", step_start, is_issue);
            chk("commit", commit, c == len);
            chk("step_sel", step_sel, (c == 1) ? m_sel : ph);
            if (c >= 2) begin
                chk("p1_latched", p1_lat, p1);
                chk("p2_latched", p2_lat, p2);
            end
        end

        m_count = (m_count + 1) % (1 << FCD);
        m_sel   = 2;
        if ((ov_a >= 1 && ov_a <= len) || (ov_b >= 1 && ov_b <= len))
            m_ov = 1;
        if (d0 > TO || d1 > TO || d2 > TO)
            m_to = 1;
    endtask

    task automatic idle_cycles(input int n, input bit done);
        for (int k = 0; k < n; k++) begin
            @(posedge sys_clk);
            #1;
            frame_tick = 1'b0;
            step_done  = done;
            @(negedge sys_clk);
            chk_idle_state();
        end
    endtask

    initial begin
        rst        = 1'b0;
        frame_tick = 1'b0;
        step_done  = 1'b0;
        p1_raw     = 5'h1f;
        p2_raw     = 5'h1f;
        repeat (2) @(negedge sys_clk);
        chk_idle_state();
        chk("rst_p1_latched", p1_lat, 0);
        chk("rst_p2_latched", p2_lat, 0);
        rst = 1'b1;

        // Minimum-length frame
        run_frame(5'h13, 5'h0a, 1, 1, 1, -1, -1);
        // Done exactly on the limit cycle of every phase
        run_frame(5'h05, 5'h1c, TO, TO, TO, -1, -1);
        // Stray done while idle
        idle_cycles(3, 1'b1);
        // Overrun ticks mid-frame and during COMMIT
        run_frame(5'h11, 5'h02, 1, 1, 1, 4, 8);
        // Phase 1 never completes
        run_frame(5'h0f, 5'h10, 2, 99, 1, -1, -1);
        idle_cycles(1, 1'b0);

        // Random frames, enough to wrap the counter
        for (int f = 0; f < 18; f++) begin
            run_frame(ID'($urandom), ID'($urandom),
                      $urandom_range(1, TO + 2),
                      $urandom_range(1, TO + 2),
                      $urandom_range(1, TO + 2),
                      ($urandom_range(0, 2) == 0) ?
                          $urandom_range(1, 12) : -1,
                      -1);
        end

        // Reset asserted in the WAIT of phase 1
        @(posedge sys_clk);
        #1;
        frame_tick = 1'b1;
        step_done  = 1'b0;
        p1_raw     = 5'h15;
        p2_raw     = 5'h0b;
        for (int c = 1; c <= 5; c++) begin
            @(posedge sys_clk);
            #1;
            frame_tick = 1'b0;
            step_done  = (c == 3);
        end
        @(negedge sys_clk);
        chk("pre_rst_busy", frame_busy, 1);
        chk("pre_rst_sel", step_sel, 1);
        #2;
        rst = 1'b0;
        #1;
        m_count = 0;
        m_ov    = 0;
        m_to    = 0;
        m_sel   = 0;
        chk_idle_state();
        chk("rst_p1_latched", p1_lat, 0);
        chk("rst_p2_latched", p2_lat, 0);
        @(negedge sys_clk);
        chk("rst_hold_commit", commit, 0);
        chk("rst_hold_busy", frame_busy, 0);
        rst = 1'b1;

        run_frame(5'h07, 5'h18, 1, 3, 2, -1, -1);
        idle_cycles(2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
